gpr_snap_reader: RTL and testbench

// - Hardware-side snapshot reader for the architectural register state (GPR mem + RAT valid/rob_id).
// - On each monitored commit inside an instruction-order window it walks x0..x31 through a 1-cycle-latency

---
 rtl/gpr_snap_reader_pkg.sv | 13 +
 rtl/gpr_snap_reader_if.sv | 31 +++
 rtl/gpr_snap_reader_fifo.sv | 35 +++
 rtl/gpr_snap_reader.sv | 81 ++++++++
 tb/tb_gpr_snap_reader.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpr_snap_reader_pkg.sv
// gpr_snap_reader_pkg: shared types for the GPR/RAT snapshot reader.
package gpr_snap_reader_pkg;
   localparam int ROB_IDX_W = 5;
   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} snap_state_t;
   typedef struct packed {
      logic [4:0]           idx;
      logic [31:0]          data;
      logic                 rat_valid;
      logic [ROB_IDX_W-1:0] tag;
      logic                 last;
      logic [15:0]          snap_id;
   } gpr_snap_rec_t;
endpackage

// File: rtl/gpr_snap_reader_if.sv
// gpr_snap_reader_if: commit monitor, GPR/RAT debug read port and record stream of the snapshot reader.
interface gpr_snap_reader_if;
   import gpr_snap_reader_pkg::*;
   logic                 mon_valid;
   logic [63:0]          mon_order;
   logic                 rd_en;
   logic [4:0]           rd_addr;
   logic [31:0]          gpr_rdata;
   logic                 rat_valid;
   logic [ROB_IDX_W-1:0] rat_rob_id;
   logic                 out_valid;
   logic                 out_ready;
   logic [4:0]           out_idx;
   logic [31:0]          out_data;
   logic                 out_rat_valid;
   logic [ROB_IDX_W-1:0] out_tag;
   logic                 out_last;
   logic [15:0]          out_snap_id;
   logic [15:0]          drop_cnt;
   logic                 done;
   modport master (
      input  mon_valid, mon_order, gpr_rdata, rat_valid, rat_rob_id, out_ready,
      output rd_en, rd_addr, out_valid, out_idx, out_data, out_rat_valid, out_tag,
             out_last, out_snap_id, drop_cnt, done
   );
   modport slave (
      output mon_valid, mon_order, gpr_rdata, rat_valid, rat_rob_id, out_ready,
      input  rd_en, rd_addr, out_valid, out_idx, out_data, out_rat_valid, out_tag,
             out_last, out_snap_id, drop_cnt, done
   );
endinterface

// File: rtl/gpr_snap_reader_fifo.sv
// gpr_snap_reader_fifo: small record FIFO (power-of-2 depth) with occupancy count.
module gpr_snap_reader_fifo
   import gpr_snap_reader_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  gpr_snap_rec_t            din_i,
   input  logic                     pop_i,
   output gpr_snap_rec_t            dout_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   gpr_snap_rec_t mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [CW-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) mem_q[wp_q] <= din_i;
         wp_q  <= wp_q + AW'(push_i);
         rp_q  <= rp_q + AW'(pop_i);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end
   assign dout_o  = mem_q[rp_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/gpr_snap_reader.sv
// gpr_snap_reader: on a windowed commit, walks x0..x31 through the GPR/RAT debug port
// and streams one record per register to a valid/ready sink.
module gpr_snap_reader
   import gpr_snap_reader_pkg::*;
#(
   parameter logic [63:0] ORDER_START = 64'd2000,
   parameter logic [63:0] ORDER_END   = 64'd2100,
   parameter int          BUF_DEPTH   = 2
) (
   input logic               clk,
   input logic               rst_n,
   gpr_snap_reader_if.master bus
);
   localparam int CW = $clog2(BUF_DEPTH) + 1;
   snap_state_t   state_q, state_d;
   logic [4:0]    idx_q, addr_q;
   logic          inflight_q;
   logic [15:0]   snap_q, drop_q;
   logic [CW-1:0] count;
   gpr_snap_rec_t rsp_rec, head_rec, out_rec;
   logic          trig, past, issue, out_valid, pop, fifo_push, fifo_pop, x0;
   assign trig = bus.mon_valid && bus.mon_order >= ORDER_START && bus.mon_order < ORDER_END;
   assign past = bus.mon_valid && bus.mon_order > ORDER_END;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d = state_q;
      if (past)                                                state_d = DONE;
      else if (state_q == IDLE && trig)                        state_d = READ;
      else if (state_q == READ && issue && idx_q == 5'd31)     state_d = DRAIN;
      else if (state_q == DRAIN && count == '0 && !inflight_q) state_d = IDLE;
   end
   // Occupancy counts in-flight reads so a response always has a buffer slot waiting.
   always_comb issue = state_q == READ && (32'(count) + 32'(inflight_q)) < BUF_DEPTH;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q      <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         snap_q     <= '0;
         drop_q     <= '0;
      end else begin
         idx_q      <= state_q == IDLE && trig ? 5'd0 : idx_q + 5'(issue);
         addr_q     <= idx_q;
         inflight_q <= issue;
         snap_q     <= snap_q + 16'(pop && out_rec.last);
         drop_q     <= drop_q + 16'(trig && (state_q == READ || state_q == DRAIN) && drop_q != 16'hFFFF);
      end
   end
   assign x0      = addr_q == 5'd0;
   assign rsp_rec = '{idx: addr_q, data: x0 ? 32'd0 : bus.gpr_rdata, rat_valid: x0 | bus.rat_valid,
                      tag: x0 ? {ROB_IDX_W{1'b0}} : bus.rat_rob_id, last: addr_q == 5'd31, snap_id: snap_q};
   // An empty buffer presents the arriving response directly; it is only stored if not taken.
   assign out_valid = count != '0 || inflight_q;
   assign out_rec   = count != '0 ? head_rec : inflight_q ? rsp_rec : '0;
   assign pop       = out_valid && bus.out_ready;
   assign fifo_pop  = pop && count != '0;
   assign fifo_push = inflight_q && !(count == '0 && bus.out_ready);
   gpr_snap_reader_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (fifo_push),
      .din_i  (rsp_rec),
      .pop_i  (fifo_pop),
      .dout_o (head_rec),
      .count_o(count)
   );
   assign bus.rd_en         = issue;
   assign bus.rd_addr       = idx_q;
   assign bus.out_valid     = out_valid;
   assign bus.out_idx       = out_rec.idx;
   assign bus.out_data      = out_rec.data;
   assign bus.out_rat_valid = out_rec.rat_valid;
   assign bus.out_tag       = out_rec.tag;
   assign bus.out_last      = out_rec.last;
   assign bus.out_snap_id   = out_rec.snap_id;
   assign bus.drop_cnt      = drop_q;
   assign bus.done          = state_q == DONE;
endmodule

// File: tb/tb_gpr_snap_reader.sv
// tb_gpr_snap_reader: randomized self-checking bench for gpr_snap_reader with a
// register-file responder and a spec-level snapshot model.
module tb_gpr_snap_reader;
   import gpr_snap_reader_pkg::*;
   logic clk = 1'b0;
   logic rst_n;
   gpr_snap_reader_if bus ();
   gpr_snap_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0]          mem   [32];
   logic                 ratv  [32];
   logic [ROB_IDX_W-1:0] ratid [32];
   gpr_snap_rec_t got [$];
   int got_cyc [$];
   int issued, popped, occ_viol, stab_viol;
   logic hold_prev;
   gpr_snap_rec_t cur, prev_rec;
   logic [15:0] exp_snap, exp_drop;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) if (bus.rd_en) begin
      bus.gpr_rdata  <= mem[bus.rd_addr];
      bus.rat_valid  <= ratv[bus.rd_addr];
      bus.rat_rob_id <= ratid[bus.rd_addr];
   end

   // Records outstanding = reads issued minus records accepted by the sink.
   always @(negedge clk) begin
      cur = '{bus.out_idx, bus.out_data, bus.out_rat_valid, bus.out_tag, bus.out_last, bus.out_snap_id};
      if (!rst_n) begin
         issued = 0;
         popped = 0;
         hold_prev = 1'b0;
      end else begin
         if (bus.rd_en && issued - popped >= 2) occ_viol++;
         if (hold_prev && (!bus.out_valid || cur !== prev_rec)) stab_viol++;
         hold_prev = bus.out_valid && !bus.out_ready;
         prev_rec = cur;
         if (bus.rd_en) issued++;
         if (bus.out_valid && bus.out_ready) begin
            got.push_back(cur);
            got_cyc.push_back(cyc);
            popped++;
         end
      end
   end

   function automatic gpr_snap_rec_t model(int i, logic [15:0] s);
      gpr_snap_rec_t r;
      r.idx       = i[4:0];
      r.data      = i == 0 ? 32'd0 : mem[i];
      r.rat_valid = i == 0 ? 1'b1 : ratv[i];
      r.tag       = i == 0 ? '0 : ratid[i];
      r.last      = i == 31;
      r.snap_id   = s;
      return r;
   endfunction

   task automatic randomize_regs();
      for (int i = 0; i < 32; i++) begin
         mem[i]   = $urandom;
         ratv[i]  = 1'($urandom_range(0, 1));
         ratid[i] = ROB_IDX_W'($urandom_range(0, 31));
      end
   endtask

   task automatic pulse(input logic [63:0] ord);
      bus.mon_valid = 1'b1;
      bus.mon_order = ord;
      @(posedge clk); #1;
      bus.mon_valid = 1'b0;
   endtask

   task automatic wait_got(input int n, input bit tog, output bit ok);
      int k = 0;
      while (got.size() < n && k < 400) begin
         @(posedge clk); #1;
         if (tog) bus.out_ready = !bus.out_ready;
         k++;
      end
      ok = got.size() >= n;
      bus.out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0) begin
         errors++; $display("FAIL reset_valid got out_valid=%b rd_en=%b exp 0 0", bus.out_valid, bus.rd_en);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.done !== 1'b0 || bus.drop_cnt !== 16'd0 || bus.out_snap_id !== 16'd0 || bus.out_data !== 32'd0) begin
         errors++;
         $display("FAIL reset_state got done=%b drop=%h snap=%h data=%h exp all 0",
                  bus.done, bus.drop_cnt, bus.out_snap_id, bus.out_data);
      end
   endtask

   task automatic test_single();
      int base = got.size();
      int t0;
      bit ok;
      for (int i = 0; i < 32; i++) begin
         mem[i]   = 32'h1000_0000 + i;
         ratv[i]  = 1'b1;
         ratid[i] = ROB_IDX_W'($urandom_range(0, 31));
      end
      mem[0]   = $urandom | 32'h1;
      ratv[0]  = 1'b0;
      ratid[0] = ROB_IDX_W'(9);
      ratv[3]  = 1'b0;
      ratid[3] = ROB_IDX_W'(7);
      t0 = cyc;
      pulse(64'd2000);
      wait_got(base + 32, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_timeout got %0d records exp 32", got.size() - base); end
      checks++;
      if (got_cyc[base] !== t0 + 2) begin
         errors++; $display("FAIL single_latency got first at %0d exp %0d", got_cyc[base], t0 + 2);
      end
      for (int i = 1; i < 32; i++) begin
         checks++;
         if (got_cyc[base + i] !== got_cyc[base] + i) begin
            errors++; $display("FAIL single_consecutive rec %0d got cyc %0d exp %0d", i, got_cyc[base + i], got_cyc[base] + i);
         end
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (got[base + i] !== model(i, exp_snap)) begin
            errors++; $display("FAIL single_rec %0d got %h exp %h", i, got[base + i], model(i, exp_snap));
         end
      end
      checks++;
      if (got[base + 5].data !== 32'h1000_0005 || got[base + 3].rat_valid !== 1'b0 || got[base + 3].tag !== ROB_IDX_W'(7)) begin
         errors++;
         $display("FAIL single_x5_x3 got x5=%h x3 rv=%b tag=%0d exp 10000005 0 7",
                  got[base + 5].data, got[base + 3].rat_valid, got[base + 3].tag);
      end
      exp_snap++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_stall();
      int base = got.size();
      bit ok;
      randomize_regs();
      pulse(64'd2000 + 64'($urandom_range(0, 99)));
      wait_got(base + 32, 1'b1, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL stall_timeout got %0d records exp 32", got.size() - base); end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (got[base + i] !== model(i, exp_snap)) begin
            errors++; $display("FAIL stall_rec %0d got %h exp %h", i, got[base + i], model(i, exp_snap));
         end
      end
      checks++;
      if (occ_viol !== 0) begin errors++; $display("FAIL stall_occupancy got %0d reads at occupancy 2 exp 0", occ_viol); end
      checks++;
      if (stab_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d unstable stalls exp 0", stab_viol); end
      exp_snap++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_drop();
      int base = got.size();
      bit ok;
      randomize_regs();
      pulse(64'd2000);
      repeat (5) @(posedge clk);
      #1;
      pulse(64'd2001);
      exp_drop++;
      wait_got(base + 32, 1'b0, ok);
      checks++;
      if (!ok || bus.drop_cnt !== exp_drop) begin
         errors++; $display("FAIL drop_cnt got %0d records drop=%0d exp 32 %0d", got.size() - base, bus.drop_cnt, exp_drop);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (got[base + i] !== model(i, exp_snap)) begin
            errors++; $display("FAIL drop_rec %0d got %h exp %h", i, got[base + i], model(i, exp_snap));
         end
      end
      exp_snap++;
      repeat (3) @(posedge clk);
      #1;
      base = got.size();
      randomize_regs();
      pulse(64'd2050);
      wait_got(base + 32, 1'b0, ok);
      checks++;
      if (!ok || got.size() != base + 32) begin
         errors++; $display("FAIL after_drain_count got %0d records exp 32", got.size() - base);
      end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (got[base + i] !== model(i, exp_snap)) begin
            errors++; $display("FAIL after_drain_rec %0d got %h exp %h", i, got[base + i], model(i, exp_snap));
         end
      end
      exp_snap++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_window();
      int base = got.size();
      int base_i = issued;
      pulse(64'd1999);
      pulse(64'd2100);
      pulse(64'($urandom_range(0, 1999)));
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got.size() != base || issued != base_i || bus.done !== 1'b0 || bus.drop_cnt !== exp_drop) begin
         errors++;
         $display("FAIL window got recs=%0d reads=%0d done=%b drop=%0d exp 0 0 0 %0d",
                  got.size() - base, issued - base_i, bus.done, bus.drop_cnt, exp_drop);
      end
   endtask

   task automatic test_reset_mid();
      int base = got.size();
      bit ok;
      randomize_regs();
      pulse(64'd2000);
      wait_got(base + 10, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL midreset_timeout got %0d records exp 10", got.size() - base); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.rd_en !== 1'b0 || bus.drop_cnt !== 16'd0 ||
          bus.out_snap_id !== 16'd0 || bus.out_idx !== 5'd0) begin
         errors++;
         $display("FAIL midreset_outputs got valid=%b rd=%b drop=%0d snap=%0d idx=%0d exp all 0",
                  bus.out_valid, bus.rd_en, bus.drop_cnt, bus.out_snap_id, bus.out_idx);
      end
      @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_snap = 16'd0;
      exp_drop = 16'd0;
      @(posedge clk); #1;
      base = got.size();
      pulse(64'd2099);
      wait_got(base + 32, 1'b0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL restart_timeout got %0d records exp 32", got.size() - base); end
      for (int i = 0; i < 32; i++) begin
         checks++;
         if (got[base + i] !== model(i, exp_snap)) begin
            errors++; $display("FAIL restart_rec %0d got %h exp %h", i, got[base + i], model(i, exp_snap));
         end
      end
      exp_snap++;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_done();
      int base = got.size();
      int base_i = issued;
      pulse(64'd2101);
      checks++;
      if (bus.done !== 1'b1) begin errors++; $display("FAIL done_set got %b exp 1", bus.done); end
      pulse(64'd2000);
      pulse(64'd2050);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (got.size() != base || issued != base_i || bus.drop_cnt !== exp_drop || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL done_absorb got recs=%0d reads=%0d drop=%0d done=%b exp 0 0 %0d 1",
                  got.size() - base, issued - base_i, bus.drop_cnt, bus.done, exp_drop);
      end
   endtask

   initial begin
      bus.mon_valid  = 1'b0;
      bus.mon_order  = '0;
      bus.out_ready  = 1'b1;
      bus.gpr_rdata  = '0;
      bus.rat_valid  = 1'b0;
      bus.rat_rob_id = '0;
      exp_snap = 16'd0;
      exp_drop = 16'd0;
      occ_viol = 0;
      stab_viol = 0;
      test_reset();
      test_single();
      test_stall();
      test_drop();
      test_window();
      test_reset_mid();
      test_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
